// File: rtl/mode_runner_if.sv
// mode_runner_if: program-control bundle for mode_runner.
//   Mode[3:0]      one-hot program select (controller -> runner)
//   Start          run request, sampled only while idle
//   Pause          freezes the active run while high
//   Abort          terminates any run
//   isRunning      high through FILL/WASH/RINSE/SPIN, including while paused
//   Phase[2:0]     0=IDLE 1=FILL 2=WASH 3=RINSE 4=SPIN 5=DONE
//   Remaining[7:0] cycles left in the current phase minus one
//   Done           one-cycle pulse on normal completion
//   Error          one-cycle pulse when Start is refused for an invalid Mode
interface mode_runner_if;
    logic [3:0] Mode;
    logic       Start;
    logic       Pause;
    logic       Abort;
    logic       isRunning;
    logic [2:0] Phase;
    logic [7:0] Remaining;
    logic       Done;
    logic       Error;

    modport master (
        output Mode, Start, Pause, Abort,
        input  isRunning, Phase, Remaining, Done, Error
    );

    modport slave (
        input  Mode, Start, Pause, Abort,
        output isRunning, Phase, Remaining, Done, Error
    );
endinterface

// File: rtl/mode_runner.sv
// mode_runner: sequences a FILL -> WASH -> RINSE -> SPIN -> DONE program.
// The WASH length depends on which one-hot Mode bit was latched at Start.
// Ports:
//   Clock  rising-edge clock for all state
//   Reset  synchronous, active-high reset
//   bus    mode_runner_if.slave: Mode/Start/Pause/Abort in,
//          isRunning/Phase/Remaining/Done/Error out (all registered)
module mode_runner #(
    parameter int unsigned FILL_LEN  = 4,
    parameter int unsigned WASH_BASE = 8,
    parameter int unsigned WASH_STEP = 4,
    parameter int unsigned RINSE_LEN = 6,
    parameter int unsigned SPIN_LEN  = 5
) (
    input  logic          Clock,
    input  logic          Reset,
    mode_runner_if.slave  bus
);

    // Encoding equals the Phase output code, so Phase is the state register.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_WASH  = 3'd2,
        ST_RINSE = 3'd3,
        ST_SPIN  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] rem_q, rem_d;
    logic [3:0] mode_q, mode_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    // WASH length for the latched mode, clamped to the 8-bit counter range.
    function automatic logic [7:0] wash_len(input logic [3:0] m);
        int unsigned s;
        s = WASH_BASE;
        for (int unsigned k = 0; k < 4; k++) begin
            if (m[k]) begin
                s = WASH_BASE + WASH_STEP * k;
            end
        end
        if (s > 255) begin
            s = 255;
        end
        return 8'(s);
    endfunction

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        error_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                rem_d = '0;
                // Abort outranks Start, so an aborting Start is neither run nor flagged.
                if (bus.Start && !bus.Abort) begin
                    if ($onehot(bus.Mode)) begin
                        mode_d  = bus.Mode;
                        state_d = ST_FILL;
                        rem_d   = 8'(FILL_LEN - 1);
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                rem_d   = '0;
            end
            default: begin
                if (bus.Abort) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                end else if (!bus.Pause) begin
                    if (rem_q == 8'd0) begin
                        unique case (state_q)
                            ST_FILL: begin
                                state_d = ST_WASH;
                                rem_d   = wash_len(mode_q) - 8'd1;
                            end
                            ST_WASH: begin
                                state_d = ST_RINSE;
                                rem_d   = 8'(RINSE_LEN - 1);
                            end
                            ST_RINSE: begin
                                state_d = ST_SPIN;
                                rem_d   = 8'(SPIN_LEN - 1);
                            end
                            ST_SPIN: begin
                                state_d = ST_DONE;
                                rem_d   = '0;
                            end
                            default: begin
                                state_d = ST_IDLE;
                                rem_d   = '0;
                            end
                        endcase
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
            end
        endcase

        running_d = (state_d == ST_FILL) || (state_d == ST_WASH) ||
                    (state_d == ST_RINSE) || (state_d == ST_SPIN);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            mode_q    <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            mode_q    <= mode_d;
            running_q <= running_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign bus.isRunning = running_q;
    assign bus.Phase     = 3'(state_q);
    assign bus.Remaining = rem_q;
    assign bus.Done      = done_q;
    assign bus.Error     = error_q;

endmodule

// File: tb/tb_mode_runner.sv
// tb_mode_runner: scoreboard bench for mode_runner. Two instances share the
// same stimulus: one with default lengths, one with unit-length phases and a
// WASH table that saturates at 255. A run-position reference model pushes the
// expected outputs per clock edge; a negedge monitor pops and compares.
module tb_mode_runner;

    localparam int unsigned F0 = 4, WB0 = 8,   WS0 = 4,  R0 = 6, S0 = 5;
    localparam int unsigned F1 = 1, WB1 = 200, WS1 = 20, R1 = 1, S1 = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mode_runner_if bus();
    mode_runner_if bus_e();

    assign bus_e.Mode  = bus.Mode;
    assign bus_e.Start = bus.Start;
    assign bus_e.Pause = bus.Pause;
    assign bus_e.Abort = bus.Abort;

    mode_runner #(.FILL_LEN(F0), .WASH_BASE(WB0), .WASH_STEP(WS0),
                  .RINSE_LEN(R0), .SPIN_LEN(S0))
        u_dut (.Clock(clk), .Reset(rst), .bus(bus.slave));

    mode_runner #(.FILL_LEN(F1), .WASH_BASE(WB1), .WASH_STEP(WS1),
                  .RINSE_LEN(R1), .SPIN_LEN(S1))
        u_edge (.Clock(clk), .Reset(rst), .bus(bus_e.slave));

    typedef struct {
        int unsigned edge_n;
        logic        run;
        logic [2:0]  ph;
        logic [7:0]  rem;
        logic        done;
        logic        err;
    } exp_t;

    exp_t sbq0[$];
    exp_t sbq1[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    // Reference model: a run is a list of four phase lengths plus a count of
    // unpaused cycles elapsed; phase and remaining follow from prefix sums.
    bit          m_run[2];
    bit          m_done[2];
    int unsigned m_t[2];
    int unsigned m_len[2][4];
    int unsigned m_total[2];

    task automatic chk(input string name, input int unsigned edge_n,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    task automatic model_step(input int unsigned inst, input logic st,
                              input logic [3:0] md, input logic pa,
                              input logic ab, input logic rs);
        exp_t        e;
        int unsigned acc, wl, fl, wb, ws, rl, sl;
        bit          found;
        fl = (inst == 0) ? F0 : F1;
        wb = (inst == 0) ? WB0 : WB1;
        ws = (inst == 0) ? WS0 : WS1;
        rl = (inst == 0) ? R0 : R1;
        sl = (inst == 0) ? S0 : S1;
        e.edge_n = edge_cnt + 1;
        e.run = 1'b0; e.ph = 3'd0; e.rem = 8'd0; e.done = 1'b0; e.err = 1'b0;

        if (rs) begin
            m_run[inst]  = 0;
            m_done[inst] = 0;
        end else if (m_done[inst]) begin
            m_done[inst] = 0;
        end else if (m_run[inst]) begin
            if (ab) begin
                m_run[inst] = 0;
            end else if (!pa) begin
                m_t[inst]++;
                if (m_t[inst] == m_total[inst]) begin
                    m_run[inst]  = 0;
                    m_done[inst] = 1;
                end
            end
        end else if (st && !ab) begin
            if ($countones(md) == 1) begin
                wl = wb;
                for (int unsigned k = 0; k < 4; k++)
                    if (md[k]) wl = wb + ws * k;
                if (wl > 255) wl = 255;
                m_len[inst][0] = fl;
                m_len[inst][1] = wl;
                m_len[inst][2] = rl;
                m_len[inst][3] = sl;
                m_total[inst]  = fl + wl + rl + sl;
                m_t[inst]      = 0;
                m_run[inst]    = 1;
            end else begin
                e.err = 1'b1;
            end
        end

        if (m_run[inst]) begin
            acc = 0;
            found = 0;
            e.run = 1'b1;
            for (int unsigned p = 0; p < 4; p++) begin
                if (!found && m_t[inst] < acc + m_len[inst][p]) begin
                    e.ph  = 3'(p + 1);
                    e.rem = 8'(acc + m_len[inst][p] - 1 - m_t[inst]);
                    found = 1;
                end
                acc += m_len[inst][p];
            end
        end else if (m_done[inst]) begin
            e.ph   = 3'd5;
            e.done = 1'b1;
        end

        if (inst == 0) sbq0.push_back(e);
        else           sbq1.push_back(e);
    endtask

    // Observation counters on the default instance, used by directed checks.
    int unsigned obs_run, obs_done, obs_err, obs_wash, first_wash_rem;
    logic [2:0]  prev_ph = 3'd0;

    task automatic clear_obs();
        obs_run = 0; obs_done = 0; obs_err = 0; obs_wash = 0;
        first_wash_rem = 999;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        while (sbq0.size() > 0 && sbq0[0].edge_n <= edge_cnt) begin
            mon_e = sbq0.pop_front();
            chk("u0.isRunning", mon_e.edge_n, 32'(bus.isRunning), 32'(mon_e.run));
            chk("u0.Phase",     mon_e.edge_n, 32'(bus.Phase),     32'(mon_e.ph));
            chk("u0.Remaining", mon_e.edge_n, 32'(bus.Remaining), 32'(mon_e.rem));
            chk("u0.Done",      mon_e.edge_n, 32'(bus.Done),      32'(mon_e.done));
            chk("u0.Error",     mon_e.edge_n, 32'(bus.Error),     32'(mon_e.err));
            if (bus.isRunning === 1'b1) obs_run++;
            if (bus.Done === 1'b1) obs_done++;
            if (bus.Error === 1'b1) obs_err++;
            if (bus.Phase === 3'd2) begin
                obs_wash++;
                if (prev_ph != 3'd2) first_wash_rem = bus.Remaining;
            end
            prev_ph = bus.Phase;
        end
        while (sbq1.size() > 0 && sbq1[0].edge_n <= edge_cnt) begin
            mon_e = sbq1.pop_front();
            chk("u1.isRunning", mon_e.edge_n, 32'(bus_e.isRunning), 32'(mon_e.run));
            chk("u1.Phase",     mon_e.edge_n, 32'(bus_e.Phase),     32'(mon_e.ph));
            chk("u1.Remaining", mon_e.edge_n, 32'(bus_e.Remaining), 32'(mon_e.rem));
            chk("u1.Done",      mon_e.edge_n, 32'(bus_e.Done),      32'(mon_e.done));
            chk("u1.Error",     mon_e.edge_n, 32'(bus_e.Error),     32'(mon_e.err));
        end
    end

    task automatic cyc(input logic st, input logic [3:0] md, input logic pa,
                       input logic ab, input logic rs);
        bus.Start = st;
        bus.Mode  = md;
        bus.Pause = pa;
        bus.Abort = ab;
        rst       = rs;
        model_step(0, st, md, pa, ab, rs);
        model_step(1, st, md, pa, ab, rs);
        @(posedge clk);
        #2;
    endtask

    // Idle cycles scramble Mode so a latched run must ignore later changes.
    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++)
            cyc(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
    endtask

    logic [3:0] mode_tbl [8];

    initial begin
        mode_tbl[0] = 4'b0001; mode_tbl[1] = 4'b0010; mode_tbl[2] = 4'b0100;
        mode_tbl[3] = 4'b1000; mode_tbl[4] = 4'b0000; mode_tbl[5] = 4'b0011;
        mode_tbl[6] = 4'b1111; mode_tbl[7] = 4'b0001;
        bus.Start = 1'b0; bus.Mode = 4'b0000; bus.Pause = 1'b0; bus.Abort = 1'b0;
        rst = 1'b1;
        clear_obs();
        @(posedge clk);
        #2;
        cyc(1'b1, 4'b0001, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Default program with a one-cycle Start pulse.
        clear_obs();
        cyc(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        idle(30);
        chk("A.run_cycles", 0, obs_run, 23);
        chk("A.done_pulses", 0, obs_done, 1);
        chk("A.wash_cycles", 0, obs_wash, 8);

        // Highest mode bit: 20-cycle WASH.
        clear_obs();
        cyc(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        idle(45);
        chk("B.wash_cycles", 0, obs_wash, 20);
        chk("B.first_wash_rem", 0, first_wash_rem, 19);
        chk("B.run_cycles", 0, obs_run, 35);

        // Pause for 3 cycles while WASH shows Remaining=5.
        clear_obs();
        cyc(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        idle(6);
        repeat (3) cyc(1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
        idle(35);
        chk("C.run_cycles", 0, obs_run, 26);
        chk("C.wash_cycles", 0, obs_wash, 11);

        // Invalid mode is refused with a single Error pulse.
        clear_obs();
        cyc(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        idle(3);
        chk("D.error_pulses", 0, obs_err, 1);
        chk("D.run_cycles", 0, obs_run, 0);

        // Abort together with Pause during RINSE.
        clear_obs();
        cyc(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        idle(13);
        cyc(1'b0, 4'b0001, 1'b1, 1'b1, 1'b0);
        idle(5);
        chk("E.done_pulses", 0, obs_done, 0);
        chk("E.run_cycles", 0, obs_run, 14);

        // Reset during SPIN, then a fresh run with mode 0010.
        clear_obs();
        cyc(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        idle(19);
        cyc(1'b0, 4'b0001, 1'b0, 1'b0, 1'b1);
        idle(3);
        chk("F.done_after_reset", 0, obs_done, 0);
        clear_obs();
        cyc(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        idle(40);
        chk("F.wash_cycles", 0, obs_wash, 12);
        chk("F.run_cycles", 0, obs_run, 27);
        chk("F.done_pulses", 0, obs_done, 1);

        // Start held high through DONE restarts immediately.
        clear_obs();
        repeat (30) cyc(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        idle(30);
        chk("G.done_pulses", 0, obs_done, 2);
        chk("G.run_cycles", 0, obs_run, 46);

        // Saturated WASH on the unit-length instance.
        cyc(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0);
        idle(262);

        // Randomized traffic.
        for (int unsigned i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 9) == 0),
                mode_tbl[$urandom_range(0, 7)],
                1'($urandom_range(0, 6) == 0),
                1'($urandom_range(0, 149) == 0),
                1'($urandom_range(0, 399) == 0));
        end
        idle(3);

        @(negedge clk);
        #1;
        chk("sb.drain0", 0, sbq0.size(), 0);
        chk("sb.drain1", 0, sbq1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
